output_accumulator_bank: RTL and testbench

Parametrised output-layer accumulator: holds NUM_OUT signed accumulators, adds one z·m product per `next_element` strobe into the currently selected accumulator with round-robin selection, then drains all results to the output RAM after `last_element`. Each result is scaled to fixed point and saturated on the way out. Sits between the activation/weight supply path and the output RAM, and replaces the fixed 8-way, non-draining accumulator stage.

---
 rtl/output_accumulator_bank.sv | 190 +++++++++++++++++++
 tb/tb_output_accumulator_bank.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_accumulator_bank.sv
// Output-layer accumulator bank: round-robin MAC into NUM_OUT accumulators,
// then drains scaled, saturated words to the output RAM (one write per cycle).
//
// Ports:
//   clock, clear_n (async active-low reset)
//   en             - start pulse, taken only in IDLE
//   active_z/m     - signed activation / weight
//   next_element   - product strobe; last_element ends the pass
//   output_ram_*   - drain write port (address, data, enable, write)
//   busy / done    - pass in progress / one-cycle drain-complete pulse
//   sat_flag       - sticky, some drained word was clamped this pass
module output_accumulator_bank #(
    parameter int NUM_OUT   = 8,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              en,
    input  logic [DATA_W-1:0] active_z,
    input  logic [DATA_W-1:0] active_m,
    input  logic              next_element,
    input  logic              last_element,
    output logic [ADDR_W-1:0] output_ram_address,
    output logic [DATA_W-1:0] output_ram_data,
    output logic              output_ram_enable,
    output logic              output_ram_write,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

    // Clamp bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] WMAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] WMIN = ~WMAX;

    state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc_q [NUM_OUT];
    logic signed [ACC_W-1:0] acc_d [NUM_OUT];

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wen_q, wen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sat_q, sat_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ADDR_W-1:0]          nxt_addr;
    logic [ADDR_W-1:0]          sel_idx;
    logic signed [ACC_W-1:0]    drain_src;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          word;
    logic                       clamp;

    assign prod     = $signed(active_z) * $signed(active_m);
    assign prod_ext = ACC_W'(prod);
    assign nxt_addr = addr_q + ADDR_W'(1);

    // State register and all datapath/output flops.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= '0;
            ptr_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_OUT; i++) acc_q[i] <= acc_d[i];
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wen_q  <= wen_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sat_q  <= sat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (en) state_d = S_ACCUM;
            S_ACCUM: if (last_element) state_d = S_DRAIN;
            S_DRAIN: if (addr_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator array and round-robin pointer.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_OUT; i++) acc_d[i] = acc_q[i];
        if (state_q == S_IDLE && en) begin
            ptr_d = '0;
            for (int i = 0; i < NUM_OUT; i++) acc_d[i] = '0;
        end else if (state_q == S_ACCUM && next_element) begin
            ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + ADDR_W'(1);
            for (int i = 0; i < NUM_OUT; i++) begin
                if (ADDR_W'(i) == ptr_q) acc_d[i] = acc_q[i] + prod_ext;
            end
        end
    end

    // Word 0 is launched on the last_element edge, so it must see the
    // same-cycle product; later words come straight from the flops.
    always_comb begin
        sel_idx   = (state_q == S_ACCUM) ? '0 : nxt_addr;
        drain_src = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (ADDR_W'(i) == sel_idx) begin
                drain_src = (state_q == S_ACCUM) ? acc_d[i] : acc_q[i];
            end
        end
        shifted = drain_src >>> FRAC_BITS;
        clamp   = 1'b0;
        word    = shifted[DATA_W-1:0];
        if (shifted > WMAX) begin
            word  = WMAX[DATA_W-1:0];
            clamp = 1'b1;
        end else if (shifted < WMIN) begin
            word  = WMIN[DATA_W-1:0];
            clamp = 1'b1;
        end
    end

    // Registered outputs.
    always_comb begin
        addr_d = '0;
        data_d = '0;
        wen_d  = 1'b0;
        done_d = 1'b0;
        sat_d  = sat_q;
        busy_d = (state_d == S_ACCUM) || (state_d == S_DRAIN);
        unique case (state_q)
            S_IDLE: begin
                if (en) sat_d = 1'b0;
            end
            S_ACCUM: begin
                if (last_element) begin
                    wen_d  = 1'b1;
                    data_d = word;
                    sat_d  = sat_q | clamp;
                end
            end
            S_DRAIN: begin
                if (addr_q == LAST_IDX) begin
                    done_d = 1'b1;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = nxt_addr;
                    data_d = word;
                    sat_d  = sat_q | clamp;
                end
            end
            default: ;
        endcase
    end

    assign output_ram_address = addr_q;
    assign output_ram_data    = data_q;
    assign output_ram_enable  = wen_q;
    assign output_ram_write   = wen_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign sat_flag           = sat_q;

endmodule

// File: tb/tb_output_accumulator_bank.sv
// Scoreboard bench for output_accumulator_bank: two instances (8 outputs Q8,
// 5 outputs no shift) driven in lockstep against an arithmetic model.
module tb_output_accumulator_bank;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] active_z = '0;
    logic [15:0] active_m = '0;
    logic        next_element = 1'b0;
    logic        last_element = 1'b0;

    logic [2:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        wen_a, wen_b, wr_a, wr_b;
    logic        busy_a, busy_b, done_a, done_b, sat_a, sat_b;

    output_accumulator_bank #(
        .NUM_OUT(8), .ADDR_W(3), .DATA_W(16), .ACC_W(32), .FRAC_BITS(8)
    ) dut_a (
        .clock(clock), .clear_n(clear_n), .en(en),
        .active_z(active_z), .active_m(active_m),
        .next_element(next_element), .last_element(last_element),
        .output_ram_address(addr_a), .output_ram_data(data_a),
        .output_ram_enable(wen_a), .output_ram_write(wr_a),
        .busy(busy_a), .done(done_a), .sat_flag(sat_a)
    );

    output_accumulator_bank #(
        .NUM_OUT(5), .ADDR_W(3), .DATA_W(16), .ACC_W(32), .FRAC_BITS(0)
    ) dut_b (
        .clock(clock), .clear_n(clear_n), .en(en),
        .active_z(active_z), .active_m(active_m),
        .next_element(next_element), .last_element(last_element),
        .output_ram_address(addr_b), .output_ram_data(data_b),
        .output_ram_enable(wen_b), .output_ram_write(wr_b),
        .busy(busy_b), .done(done_b), .sat_flag(sat_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int addr; int data; int cyc;} wr_t;
    typedef struct {int cyc; bit sat;} dn_t;

    wr_t qa[$], qb[$];
    dn_t da[$], db[$];

    int n_checks = 0;
    int n_fail = 0;

    localparam int NO[2] = '{8, 5};
    localparam int FB[2] = '{8, 0};
    int acc_m[2][8];
    int ptr_m[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) @cyc %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic, int wraps like ACC_W=32.
    task automatic m_clear();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0;
            for (int i = 0; i < 8; i++) acc_m[d][i] = 0;
        end
    endtask

    task automatic m_strobe(input logic [15:0] z, input logic [15:0] m);
        int p;
        p = int'($signed(z)) * int'($signed(m));
        for (int d = 0; d < 2; d++) begin
            acc_m[d][ptr_m[d]] = acc_m[d][ptr_m[d]] + p;
            ptr_m[d] = (ptr_m[d] + 1) % NO[d];
        end
    endtask

    task automatic m_drain(input int lc);
        for (int d = 0; d < 2; d++) begin
            bit s = 0;
            for (int i = 0; i < NO[d]; i++) begin
                int w = acc_m[d][i] >>> FB[d];
                if (w > 32767) begin
                    w = 32767; s = 1;
                end else if (w < -32768) begin
                    w = -32768; s = 1;
                end
                if (d == 0) qa.push_back('{i, w & 32'hFFFF, lc + i});
                else        qb.push_back('{i, w & 32'hFFFF, lc + i});
            end
            if (d == 0) da.push_back('{lc + NO[d], s});
            else        db.push_back('{lc + NO[d], s});
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a write or done.
    task automatic mon(input int d, input logic we, input logic wr,
                       input int ad, input int dt, input logic dn,
                       input logic bs, input logic sf);
        wr_t e;
        dn_t f;
        bit got;
        string t = (d == 0) ? "A" : "B";
        if (we) begin
            got = 0;
            if (d == 0 && qa.size() > 0) begin e = qa.pop_front(); got = 1; end
            if (d == 1 && qb.size() > 0) begin e = qb.pop_front(); got = 1; end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write_%s: addr %0d data 0x%0h, want none @cyc %0d",
                         t, ad, dt, cyc);
            end else begin
                chk({"wr_addr_", t}, ad, e.addr);
                chk({"wr_data_", t}, dt, e.data);
                chk({"wr_cycle_", t}, cyc, e.cyc);
                chk({"wr_strobe_", t}, int'(wr), 1);
            end
        end
        if (dn) begin
            got = 0;
            if (d == 0 && da.size() > 0) begin f = da.pop_front(); got = 1; end
            if (d == 1 && db.size() > 0) begin f = db.pop_front(); got = 1; end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done_%s: done=1, want 0 @cyc %0d", t, cyc);
            end else begin
                chk({"done_cycle_", t}, cyc, f.cyc);
                chk({"done_busy_", t}, int'(bs), 0);
                chk({"sat_flag_", t}, int'(sf), int'(f.sat));
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, wen_a, wr_a, int'(addr_a), int'(data_a), done_a, busy_a, sat_a);
        mon(1, wen_b, wr_b, int'(addr_b), int'(data_b), done_b, busy_b, sat_b);
    end

    task automatic step(input bit nx, input bit ls, input bit e,
                        input logic [15:0] z, input logic [15:0] m);
        next_element = nx;
        last_element = ls;
        en = e;
        active_z = z;
        active_m = m;
        @(posedge clock);
        #1;
        next_element = 1'b0;
        last_element = 1'b0;
        en = 1'b0;
    endtask

    task automatic start_pass();
        step(0, 0, 1, 16'($urandom), 16'($urandom));
        m_clear();
        chk("busy_after_en_A", int'(busy_a), 1);
    endtask

    task automatic strobe(input logic [15:0] z, input logic [15:0] m,
                          input bit ls);
        step(1, ls, 0, z, m);
        m_strobe(z, m);
        if (ls) m_drain(cyc);
    endtask

    task automatic last_only();
        step(0, 1, 0, 16'($urandom), 16'($urandom));
        m_drain(cyc);
    endtask

    // Drain with ignored strobes thrown at the DUTs; bounded wait.
    task automatic wait_drain(input bit noise);
        for (int k = 0; k < 40; k++) begin
            if (qa.size() == 0 && qb.size() == 0 &&
                da.size() == 0 && db.size() == 0) break;
            step(noise & $urandom_range(0, 1), noise & $urandom_range(0, 1), 0,
                 16'($urandom), 16'($urandom));
        end
        chk("drain_pending", qa.size() + qb.size() + da.size() + db.size(), 0);
        step(0, 0, 0, 0, 0);
    endtask

    function automatic logic [15:0] rnd_val();
        unique case ($urandom_range(0, 2))
            0: return 16'($urandom_range(0, 1023));
            1: return 16'(-int'($urandom_range(0, 1023)));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        m_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_data", int'(data_a), 0);
        chk("rst_enable", int'(wen_a), 0);
        chk("rst_write", int'(wr_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_sat", int'(sat_a), 0);
        clear_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Single pass, 1.0 * 2.0 in Q8, sixteen strobes.
        start_pass();
        for (int i = 0; i < 15; i++) strobe(16'h0100, 16'h0200, 0);
        strobe(16'h0100, 16'h0200, 0);
        last_only();
        wait_drain(0);

        // Negative products, nine strobes: ptr wraps onto slot 0.
        start_pass();
        for (int i = 0; i < 9; i++) strobe(16'hFF00, 16'h0100, 0);
        last_only();
        wait_drain(0);

        // Saturation both ways, last with a same-cycle strobe.
        start_pass();
        strobe(16'h7FFF, 16'h7FFF, 0);
        strobe(16'h7FFF, 16'h7FFF, 0);
        strobe(16'h7FFF, 16'h7FFF, 0);
        strobe(16'h8000, 16'h7FFF, 1);
        wait_drain(0);

        // Empty pass.
        start_pass();
        last_only();
        wait_drain(0);

        // Ignore rules: en during ACCUM, strobes during DRAIN.
        start_pass();
        strobe(16'h0300, 16'h0100, 0);
        step(0, 0, 1, 16'h1234, 16'h1234);
        strobe(16'hFD00, 16'h0040, 0);
        step(0, 0, 1, 0, 0);
        strobe(16'h0123, 16'h0456, 1);
        wait_drain(1);

        // Reset on the third write.
        start_pass();
        for (int i = 0; i < 6; i++) strobe(16'h0200, 16'h0100, 0);
        last_only();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("third_write_enable", int'(wen_a), 1);
        chk("third_write_addr", int'(addr_a), 2);
        clear_n = 1'b0;
        #1;
        chk("rstmid_enable", int'(wen_a), 0);
        chk("rstmid_write", int'(wr_a), 0);
        chk("rstmid_addr", int'(addr_a), 0);
        chk("rstmid_data", int'(data_a), 0);
        chk("rstmid_busy", int'(busy_a), 0);
        chk("rstmid_enable_B", int'(wen_b), 0);
        qa.delete(); qb.delete(); da.delete(); db.delete();
        m_clear();
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        repeat (12) step(0, 0, 0, 0, 0);

        // Follow-up pass must start from zeroed accumulators.
        start_pass();
        strobe(16'h0100, 16'h0100, 0);
        last_only();
        wait_drain(0);

        // Randomized passes.
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(0, 24);
            start_pass();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0)
                    step(0, 0, $urandom_range(0, 1), rnd_val(), rnd_val());
                strobe(rnd_val(), rnd_val(), 0);
            end
            if ($urandom_range(0, 1) == 1) strobe(rnd_val(), rnd_val(), 1);
            else last_only();
            wait_drain(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
